hazard_issue_ctrl: RTL and testbench

- Issue controller between the decode (DE) and execute (EX) stages.
- Keeps a scoreboard of in-flight scalar, vector and condition-code (CC) writes. Stalls DE on RAW or WAW hazards, GPU-stage backpressure and unresolved branches.
- Raises a one-cycle flush on taken branches and counts stall cycles for performance monitoring.

---
 rtl/hazard_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_issue_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_issue_ctrl.sv
// DE->EX issue controller: scalar/vector/CC write scoreboard, hazard stalls,
// branch-wait FSM with one-cycle flush, and a saturating stall-cycle counter.
module hazard_issue_ctrl #(
  parameter int unsigned NUM_RF         = 16,
  parameter int unsigned NUM_VRF        = 64,
  parameter int unsigned VREG_ID_WIDTH  = 6,
  parameter int unsigned STALLCNT_WIDTH = 16
) (
  input  logic                      I_CLOCK,
  input  logic                      I_RESET,
  input  logic                      I_DE_Valid,
  input  logic                      I_Src1Used,
  input  logic                      I_Src2Used,
  input  logic [3:0]                I_Src1RegIdx,
  input  logic [3:0]                I_Src2RegIdx,
  input  logic                      I_VSrc1Used,
  input  logic                      I_VSrc2Used,
  input  logic [VREG_ID_WIDTH-1:0]  I_VSrc1RegIdx,
  input  logic [VREG_ID_WIDTH-1:0]  I_VSrc2RegIdx,
  input  logic                      I_RegWEn,
  input  logic [3:0]                I_DestRegIdx,
  input  logic                      I_VRegWEn,
  input  logic [VREG_ID_WIDTH-1:0]  I_DestVRegIdx,
  input  logic                      I_CCRead,
  input  logic                      I_CCWEn,
  input  logic                      I_IsBranch,
  input  logic                      I_GPUStallSignal,
  input  logic                      I_EX_BranchResolved,
  input  logic                      I_EX_BranchTaken,
  input  logic                      I_WB_RegWEn,
  input  logic [3:0]                I_WB_DestRegIdx,
  input  logic                      I_WB_VRegWEn,
  input  logic [VREG_ID_WIDTH-1:0]  I_WB_DestVRegIdx,
  input  logic                      I_WB_CCWEn,
  output logic                      O_Issue,
  output logic                      O_DE_Stall,
  output logic                      O_FE_Stall,
  output logic                      O_Flush,
  output logic                      O_Error,
  output logic [STALLCNT_WIDTH-1:0] O_StallCount
);

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t                    state, state_nxt;
  logic [NUM_RF-1:0]         busy_r, busy_r_nxt;
  logic [NUM_VRF-1:0]        busy_v, busy_v_nxt;
  logic                      busy_cc, busy_cc_nxt;
  logic                      error_nxt, flush_nxt;
  logic                      hazard;
  logic [STALLCNT_WIDTH-1:0] count_nxt;

  // Hazard looks only at registered busy bits; a same-cycle retire does not unblock.
  always_comb begin
    hazard = (I_Src1Used  & busy_r[I_Src1RegIdx])
           | (I_Src2Used  & busy_r[I_Src2RegIdx])
           | (I_VSrc1Used & busy_v[I_VSrc1RegIdx])
           | (I_VSrc2Used & busy_v[I_VSrc2RegIdx])
           | (I_RegWEn    & busy_r[I_DestRegIdx])
           | (I_VRegWEn   & busy_v[I_DestVRegIdx])
           | ((I_CCRead | I_CCWEn) & busy_cc);
    O_DE_Stall = I_DE_Valid & (hazard | I_GPUStallSignal | (state == BR_WAIT));
    O_Issue    = I_DE_Valid & ~O_DE_Stall;
    O_FE_Stall = O_DE_Stall | (state == BR_WAIT);
  end

  // Retire clears are applied before issue sets; link registers arrive via I_RegWEn.
  always_comb begin
    busy_r_nxt  = busy_r;
    busy_v_nxt  = busy_v;
    busy_cc_nxt = busy_cc;
    error_nxt   = O_Error;
    if (I_WB_RegWEn) begin
      if (!busy_r[I_WB_DestRegIdx]) error_nxt = 1'b1;
      busy_r_nxt[I_WB_DestRegIdx] = 1'b0;
    end
    if (I_WB_VRegWEn) begin
      if (!busy_v[I_WB_DestVRegIdx]) error_nxt = 1'b1;
      busy_v_nxt[I_WB_DestVRegIdx] = 1'b0;
    end
    if (I_WB_CCWEn) begin
      if (!busy_cc) error_nxt = 1'b1;
      busy_cc_nxt = 1'b0;
    end
    if (O_Issue) begin
      if (I_RegWEn)  busy_r_nxt[I_DestRegIdx]  = 1'b1;
      if (I_VRegWEn) busy_v_nxt[I_DestVRegIdx] = 1'b1;
      if (I_CCWEn)   busy_cc_nxt               = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = 1'b0;
    case (state)
      IDLE:    if (O_Issue && I_IsBranch) state_nxt = BR_WAIT;
      BR_WAIT: if (I_EX_BranchResolved) begin
                 state_nxt = IDLE;
                 flush_nxt = I_EX_BranchTaken;
               end
      default: state_nxt = IDLE;
    endcase
    count_nxt = O_StallCount;
    if (O_DE_Stall && !(&O_StallCount)) count_nxt = O_StallCount + 1'b1;
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state        <= IDLE;
      busy_r       <= '0;
      busy_v       <= '0;
      busy_cc      <= 1'b0;
      O_Flush      <= 1'b0;
      O_Error      <= 1'b0;
      O_StallCount <= '0;
    end else begin
      state        <= state_nxt;
      busy_r       <= busy_r_nxt;
      busy_v       <= busy_v_nxt;
      busy_cc      <= busy_cc_nxt;
      O_Flush      <= flush_nxt;
      O_Error      <= error_nxt;
      O_StallCount <= count_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Directed-vector bench: each stimulus cycle pushes its hand-computed expected
// outputs into a queue; a monitor pops and compares them mid-cycle.
module tb_hazard_issue_ctrl;

  logic       clk, rst;
  logic       de_valid, src1_used, src2_used, vsrc1_used, vsrc2_used;
  logic [3:0] src1_idx, src2_idx, dest_idx, wb_dest_idx;
  logic [5:0] vsrc1_idx, vsrc2_idx, dest_vidx, wb_dest_vidx;
  logic       reg_wen, vreg_wen, cc_read, cc_wen, is_branch, gpu_stall;
  logic       br_resolved, br_taken, wb_reg_wen, wb_vreg_wen, wb_cc_wen;
  logic       issue, de_stall, fe_stall, flush, error;
  logic [15:0] stall_count;

  typedef struct packed {
    logic       rst, valid, s1u, s2u;
    logic [3:0] s1, s2;
    logic       v1u, v2u;
    logic [5:0] v1, v2;
    logic       rwe;
    logic [3:0] rd;
    logic       vwe;
    logic [5:0] vd;
    logic       ccr, ccw, br, gpu, res, tkn, wbr;
    logic [3:0] wbrd;
    logic       wbv;
    logic [5:0] wbvd;
    logic       wbcc;
  } vec_t;

  typedef struct packed {
    logic        issue, de, fe, flush, err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  hazard_issue_ctrl #(.NUM_RF(16), .NUM_VRF(64), .VREG_ID_WIDTH(6), .STALLCNT_WIDTH(16)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_DE_Valid(de_valid),
    .I_Src1Used(src1_used), .I_Src2Used(src2_used),
    .I_Src1RegIdx(src1_idx), .I_Src2RegIdx(src2_idx),
    .I_VSrc1Used(vsrc1_used), .I_VSrc2Used(vsrc2_used),
    .I_VSrc1RegIdx(vsrc1_idx), .I_VSrc2RegIdx(vsrc2_idx),
    .I_RegWEn(reg_wen), .I_DestRegIdx(dest_idx),
    .I_VRegWEn(vreg_wen), .I_DestVRegIdx(dest_vidx),
    .I_CCRead(cc_read), .I_CCWEn(cc_wen), .I_IsBranch(is_branch),
    .I_GPUStallSignal(gpu_stall),
    .I_EX_BranchResolved(br_resolved), .I_EX_BranchTaken(br_taken),
    .I_WB_RegWEn(wb_reg_wen), .I_WB_DestRegIdx(wb_dest_idx),
    .I_WB_VRegWEn(wb_vreg_wen), .I_WB_DestVRegIdx(wb_dest_vidx),
    .I_WB_CCWEn(wb_cc_wen),
    .O_Issue(issue), .O_DE_Stall(de_stall), .O_FE_Stall(fe_stall),
    .O_Flush(flush), .O_Error(error), .O_StallCount(stall_count)
  );

  // Active edge is negedge (t=5,15,...); drive at posedge+1, check at posedge+3.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    rst = v.rst; de_valid = v.valid;
    src1_used = v.s1u; src2_used = v.s2u; src1_idx = v.s1; src2_idx = v.s2;
    vsrc1_used = v.v1u; vsrc2_used = v.v2u; vsrc1_idx = v.v1; vsrc2_idx = v.v2;
    reg_wen = v.rwe; dest_idx = v.rd; vreg_wen = v.vwe; dest_vidx = v.vd;
    cc_read = v.ccr; cc_wen = v.ccw; is_branch = v.br; gpu_stall = v.gpu;
    br_resolved = v.res; br_taken = v.tkn;
    wb_reg_wen = v.wbr; wb_dest_idx = v.wbrd;
    wb_vreg_wen = v.wbv; wb_dest_vidx = v.wbvd; wb_cc_wen = v.wbcc;
  endtask

  task automatic step(input vec_t v, input logic e_iss, input logic e_de, input logic e_fe,
                      input logic e_fl, input logic e_err, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.issue = e_iss; e.de = e_de; e.fe = e_fe; e.flush = e_fl; e.err = e_err; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a.issue = issue; a.de = de_stall; a.fe = fe_stall; a.flush = flush; a.err = error;
      a.cnt = stall_count;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL step%0d outputs: got issue=%b de_stall=%b fe_stall=%b flush=%b error=%b cnt=%0d, expected issue=%b de_stall=%b fe_stall=%b flush=%b error=%b cnt=%0d",
                 step_no, a.issue, a.de, a.fe, a.flush, a.err, a.cnt,
                 e.issue, e.de, e.fe, e.flush, e.err, e.cnt);
      end
      step_no++;
    end
  end

  initial begin
    vec_t z, v;
    int   guard;
    z = '0;
    z.rst = 1'b1;
    drive(z);
    z.rst = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    step(z, 0,0,0,0,0, 0);

    // RAW on R1: issue, stall twice (retire in the second), then issue
    v = z; v.valid = 1; v.rwe = 1; v.rd = 1;           step(v, 1,0,0,0,0, 0);
    v = z; v.valid = 1; v.s1u = 1; v.s1 = 1; v.rwe = 1; v.rd = 2;
                                                       step(v, 0,1,1,0,0, 0);
    v.wbr = 1; v.wbrd = 1;                             step(v, 0,1,1,0,0, 1);
    v.wbr = 0;                                         step(v, 1,0,0,0,0, 2);
    v = z; v.wbr = 1; v.wbrd = 2;                      step(v, 0,0,0,0,0, 2);

    // CMPI then BRZ: CC hazard, branch wait, taken -> one-cycle flush
    v = z; v.valid = 1; v.ccw = 1;                     step(v, 1,0,0,0,0, 2);
    v = z; v.valid = 1; v.ccr = 1; v.br = 1;           step(v, 0,1,1,0,0, 2);
    v.wbcc = 1;                                        step(v, 0,1,1,0,0, 3);
    v.wbcc = 0;                                        step(v, 1,0,0,0,0, 4);
    step(z, 0,0,1,0,0, 4);
    v = z; v.valid = 1; v.res = 1; v.tkn = 1;          step(v, 0,1,1,0,0, 4);
    step(z, 0,0,0,1,0, 5);
    v = z; v.res = 1; v.tkn = 1;                       step(v, 0,0,0,0,0, 5);
    step(z, 0,0,0,0,0, 5);

    // not-taken branch: no flush, issue resumes next cycle
    v = z; v.valid = 1; v.br = 1;                      step(v, 1,0,0,0,0, 5);
    v = z; v.valid = 1; v.res = 1;                     step(v, 0,1,1,0,0, 5);
    v = z; v.valid = 1;                                step(v, 1,0,0,0,0, 6);

    // GPU backpressure: no issue, no busy set, counter runs
    v = z; v.valid = 1; v.rwe = 1; v.rd = 6; v.gpu = 1; step(v, 0,1,1,0,0, 6);
    v = z; v.valid = 1; v.s1u = 1; v.s1 = 6;           step(v, 1,0,0,0,0, 7);

    // retire to idle vector reg 5: sticky error, busy_v[5] stays clear
    v = z; v.wbv = 1; v.wbvd = 5;                      step(v, 0,0,0,0,0, 7);
    step(z, 0,0,0,0,1, 7);
    v = z; v.valid = 1; v.v1u = 1; v.v1 = 5;           step(v, 1,0,0,0,1, 7);

    // vector RAW on V9
    v = z; v.valid = 1; v.vwe = 1; v.vd = 9;           step(v, 1,0,0,0,1, 7);
    v = z; v.valid = 1; v.v2u = 1; v.v2 = 9;           step(v, 0,1,1,0,1, 7);
    v = z; v.wbv = 1; v.wbvd = 9;                      step(v, 0,0,0,0,1, 8);

    // async reset during BR_WAIT with R3 busy
    v = z; v.valid = 1; v.rwe = 1; v.rd = 3;           step(v, 1,0,0,0,1, 8);
    v = z; v.valid = 1; v.br = 1;                      step(v, 1,0,0,0,1, 8);
    step(z, 0,0,1,0,1, 8);
    v = z; v.rst = 1;                                  step(v, 0,0,0,0,0, 0);
    v = z; v.valid = 1; v.s1u = 1; v.s1 = 3; v.rwe = 1; v.rd = 3;
                                                       step(v, 1,0,0,0,0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
